// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, mul/div hold, jump/branch flush.
// Ports: hazard inputs from ID/EX/MEM, pipe-register enables, md status, stats counters.
module pipe_hazard_ctrl #(
  parameter int ADDR_SIZE = 5,
  parameter int MD_LAT    = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE-1:0] id_rs,
  input  logic [ADDR_SIZE-1:0] id_rt,
  input  logic                 id_uses_rt,
  input  logic                 id_jump,
  input  logic                 idex_mem_read,
  input  logic [ADDR_SIZE-1:0] idex_rt,
  input  logic                 ex_md_start,
  input  logic                 mem_branch_taken,
  output logic                 pc_we,
  output logic                 ifid_we,
  output logic                 ifid_flush,
  output logic                 idex_we,
  output logic                 idex_bubble,
  output logic                 md_busy,
  output logic                 md_done,
  output logic                 md_abort,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  typedef enum logic {
    RUN,
    MD_WAIT
  } state_t;

  localparam logic [7:0] MD_INIT = 8'(MD_LAT - 2);

  state_t     state_q, state_d;
  logic [7:0] md_cnt_q, md_cnt_d;
  logic       lu;

  assign lu = idex_mem_read
           && (idex_rt != '0)
           && ((idex_rt == id_rs)
            || (id_uses_rt && (idex_rt == id_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_we     = 1'b1;
    idex_bubble = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    md_abort    = 1'b0;
    if (!rst_n) begin
      // reset drives the pipe quiet without waiting for a clock
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      md_busy = (state_q == MD_WAIT);
      if (mem_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        md_abort    = (state_q == MD_WAIT) || ex_md_start;
        state_d     = RUN;
        md_cnt_d    = '0;
      end else if (state_q == MD_WAIT) begin
        if (md_cnt_q != '0) begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          idex_we  = 1'b0;
          md_cnt_d = md_cnt_q - 8'd1;
        end else begin
          md_done = 1'b1;
          state_d = RUN;
        end
      end else if (ex_md_start) begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        state_d  = MD_WAIT;
        md_cnt_d = MD_INIT;
      end else if (lu) begin
        // the bubble clears idex_mem_read, so this lasts one cycle
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic
// against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 6;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] id_rs, id_rt, idex_rt;
  logic          id_uses_rt, id_jump, idex_mem_read;
  logic          ex_md_start, mem_branch_taken;
  logic          pc_we, ifid_we, ifid_flush, idex_we;
  logic          idex_bubble, md_busy, md_done, md_abort;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  // model: whether an op is in its wait phase and how many
  // cycles it has already spent in EX
  bit m_md;
  int m_age;
  int m_stall;
  int m_flush;

  pipe_hazard_ctrl #(
    .ADDR_SIZE(AW), .MD_LAT(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ex_md_start(ex_md_start),
    .mem_branch_taken(mem_branch_taken),
    .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_we(idex_we),
    .idex_bubble(idex_bubble), .md_busy(md_busy),
    .md_done(md_done), .md_abort(md_abort),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; idex_rt = '0;
    id_uses_rt = 0; id_jump = 0; idex_mem_read = 0;
    ex_md_start = 0; mem_branch_taken = 0;
  endtask

  // inputs are applied just after a negedge; this checks the
  // cycle, advances the model and waits for the next negedge
  task automatic step(input string tag);
    logic [7:0] e;
    bit lu;
    bit hold;
    #1;
    if (!rst_n) begin
      m_md = 0; m_age = 0; m_stall = 0; m_flush = 0;
    end
    lu = idex_mem_read && (idex_rt != 0) &&
         (idex_rt == id_rs ||
          (id_uses_rt && idex_rt == id_rt));
    // {pc,ifid,flush,idex,bubble,busy,done,abort}
    e = 8'b1101_0000;
    hold = 0;
    if (!rst_n) e = 8'b0000_1000;
    else begin
      e[2] = m_md;
      if (mem_branch_taken) begin
        e[5] = 1; e[3] = 1;
        e[0] = m_md || ex_md_start;
      end else if (m_md) begin
        if (m_age < LAT - 1) hold = 1;
        else e[1] = 1;
      end else if (ex_md_start) begin
        hold = 1;
      end else if (lu) begin
        e[7] = 0; e[6] = 0; e[3] = 1;
      end else if (id_jump) begin
        e[5] = 1;
      end
      if (hold) begin
        e[7] = 0; e[6] = 0; e[4] = 0;
      end
    end
    chk(tag, {pc_we, ifid_we, ifid_flush, idex_we,
              idex_bubble, md_busy, md_done, md_abort}, e);
    chk({tag, "_stall"}, stall_cnt, m_stall);
    chk({tag, "_flush"}, flush_cnt, m_flush);
    if (rst_n) begin
      if (!e[7] && m_stall < SAT) m_stall++;
      if (e[5] && m_flush < SAT) m_flush++;
      if (mem_branch_taken) m_md = 0;
      else if (m_md) begin
        if (m_age >= LAT - 1) m_md = 0;
        else m_age++;
      end else if (ex_md_start) begin
        m_md = 1; m_age = 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    m_md = 0; m_age = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    step("reset0");
    step("reset1");
    rst_n = 1;
    step("idle");

    // load-use on rs, then the bubble removes the load
    idex_mem_read = 1; idex_rt = 5; id_rs = 5;
    step("lu_rs");
    idex_mem_read = 0;
    step("lu_after");
    idex_mem_read = 1; idex_rt = 0; id_rs = 0;
    step("lu_r0");
    idle();

    // rt hazard only when rt is a source
    idex_mem_read = 1; idex_rt = 7; id_rt = 7; id_rs = 1;
    step("rt_unused");
    id_uses_rt = 1;
    step("rt_used");
    idle();
    step("idle2");

    // full mul/div: 3 holds then done
    ex_md_start = 1;
    step("md_t0");
    step("md_t1");
    step("md_t2");
    step("md_t3");
    ex_md_start = 0;
    step("md_after");

    // branch kills the op in its wait phase
    ex_md_start = 1;
    step("ab_t0");
    mem_branch_taken = 1;
    step("ab_t1");
    mem_branch_taken = 0; ex_md_start = 0;
    step("ab_t2");

    // jump suppressed by load-use, then taken
    id_jump = 1; idex_mem_read = 1;
    idex_rt = 3; id_rs = 3;
    step("jmp_lu");
    idex_mem_read = 0;
    step("jmp_go");
    idle();

    // branch kills an op as it starts
    ex_md_start = 1; mem_branch_taken = 1;
    step("ab_start");
    idle();
    step("ab_start_after");

    // async reset in the middle of a wait
    ex_md_start = 1;
    step("rst_t0");
    step("rst_t1");
    rst_n = 0;
    step("rst_mid");
    rst_n = 1; ex_md_start = 0;
    step("rst_rel");

    for (int i = 0; i < 4000; i++) begin
      id_rs = AW'($urandom_range(0, 3));
      id_rt = AW'($urandom_range(0, 3));
      idex_rt = AW'($urandom_range(0, 3));
      id_uses_rt = ($urandom_range(0, 1) == 1);
      id_jump = ($urandom_range(0, 3) == 0);
      idex_mem_read = ($urandom_range(0, 1) == 1);
      ex_md_start = ($urandom_range(0, 9) == 0);
      mem_branch_taken = ($urandom_range(0, 11) == 0);
      rst_n = ($urandom_range(0, 799) != 0);
      step("rand");
      rst_n = 1;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
